// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter family.
// Helpers are written for the widest legal arbiter and are truncated by callers.
package arb_pkg;

  localparam int ARB_N_MAX   = 32;
  localparam int ARB_IDW_MAX = $clog2(ARB_N_MAX);

  // One-hot to binary index; a zero input yields 0.
  function automatic logic [ARB_IDW_MAX-1:0] arb_onehot2bin(
    input logic [ARB_N_MAX-1:0] oh
  );
    logic [ARB_IDW_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N_MAX; i++) begin
      if (oh[i]) begin
        idx = idx | ARB_IDW_MAX'(i);
      end
    end
    return idx;
  endfunction

  // (idx + 1) mod n with an explicit compare, so n need not be a power of two.
  function automatic logic [ARB_IDW_MAX-1:0] arb_next_ptr(
    input logic [ARB_IDW_MAX-1:0] idx,
    input logic [ARB_IDW_MAX:0]   n
  );
    logic [ARB_IDW_MAX:0] last;
    last = n - (ARB_IDW_MAX+1)'(1);
    if ({1'b0, idx} == last) begin
      return '0;
    end
    return idx + ARB_IDW_MAX'(1);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
// Zero latency; found is low and winner is zero when nothing requests.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   winner,
  output logic           found
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_src;

  // Bits at or above ptr get first pick; the unmasked vector covers the wrap.
  assign mask     = ~((N'(1) << ptr) - N'(1));
  assign masked   = request & mask;
  assign pick_src = (|masked) ? masked : request;
  assign winner   = pick_src & (~pick_src + N'(1));
  assign found    = |request;

endmodule

// File: rtl/arb_rr_n.sv
// N-way round-robin arbiter with registered one-hot grant; 1-cycle request-to-grant, no backpressure.
// Define ARB_LOCK_EN to add a lock input that lets the current grantee keep the grant.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   request,
`ifdef ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  logic [N-1:0]   grant_q;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [N-1:0]   pick_oh;
  logic           pick_found;
  logic [IDW-1:0] win_id;
  logic           hold;

  arb_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .request (request),
    .ptr     (ptr_q),
    .winner  (pick_oh),
    .found   (pick_found)
  );

  assign win_id = IDW'(arb_onehot2bin(ARB_N_MAX'(pick_oh)));

`ifdef ARB_LOCK_EN
  // Lock only holds while the grantee still requests; otherwise arbitrate normally.
  assign hold = lock & (|(grant_q & request));
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    grant_d = pick_oh;
    ptr_d   = ptr_q;
    if (hold) begin
      grant_d = grant_q;
    end else if (pick_found) begin
      ptr_d = IDW'(arb_next_ptr(ARB_IDW_MAX'(win_id), (ARB_IDW_MAX+1)'(N)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = IDW'(arb_onehot2bin(ARB_N_MAX'(grant_q)));

endmodule

// File: doc/arb_rr_n.md
# arb_rr_n

Parametrised N-requester round-robin arbiter with a registered one-hot grant. It is the next generation of the two-requester arbiter that the port-communication bench drives. It sits between N request sources and one shared resource, so a port-connected test can drive `request` and check `grant` a fixed number of cycles later. Fairness is round-robin, and an optional lock lets the current winner keep the grant for multi-cycle transfers.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `IDW`, default `$clog2(N)`: width of `grant_id`; derived, never overridden.

Ports:
- `clk`  in  1: single clock; every state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `request`  in  N: bit i high means requester i wants the resource.
- `lock`  in  1: hold the current grant. Present only with `ARB_LOCK_EN`.
- `grant`  out  N: registered grant, one-hot or zero.
- `grant_valid`  out  1: high when `grant` is non-zero.
- `grant_id`  out  IDW: binary index of the granted requester; 0 when `grant_valid` is 0.

## Operation
- State:
  - priority pointer `ptr` (IDW bits) naming the highest-priority requester;
  - registered `grant`.
- On every rising edge with `rst`=0:
  - Search `request` starting at index `ptr`, ascending, wrapping from N-1 to 0.
  - The first set bit wins; its one-hot bit is written to `grant`.
  - `ptr` becomes (winner+1) mod N. The wrap uses an explicit compare, because N need not be a power of two.
- When `request` is all zero:
  - `grant`, `grant_valid` and `grant_id` are all 0;
  - `ptr` is unchanged.
- A requester that holds `request` high continuously alternates with every other active requester. No requester waits more than N-1 grants.
- Outputs are combinational decodes of the `grant` register. `grant_valid` is the OR of `grant`; `grant_id` is the encoded index.
- Reset values:
  - `grant`=0, `grant_valid`=0, `grant_id`=0;
  - `ptr`=0, so requester 0 has highest priority first.
- Reset mid-operation: the outstanding grant is dropped on the reset edge. While `rst` is high, `request` is ignored.

## Timing
- Latency is one cycle:
  - `request` is sampled at edge T;
  - the resulting `grant` is visible from just after edge T until edge T+1.
- A driver that updates `request` with a non-blocking assign at edge T0 sees the grant after edge T0+1. A bench checking two edges after driving therefore observes a stable grant.
- Deasserting a request removes its grant one edge later. There is no explicit release handshake.
- The first grant after reset is produced on the first edge with `rst`=0.
- Simultaneous events:
  - a new request and the drop of the current grantee's request in the same cycle are resolved in one arbitration;
  - there is no idle bubble between them.

## Configuration
- Macro: `ARB_LOCK_EN`.
- Defined:
  - The `lock` port exists.
  - If `lock`=1 at an edge and the currently granted requester still has `request` high, then `grant` and `ptr` hold.
  - If the grantee has dropped its request, `lock` is ignored and normal arbitration runs.
  - `lock` with no current grant has no effect.
- Not defined:
  - The `lock` port is absent.
  - The grant is re-arbitrated every cycle.

## Structure
- Package `arb_pkg` holds:
  - `ARB_N_MAX` = 32;
  - function `arb_onehot2bin` (one-hot to index);
  - function `arb_next_ptr` (wrap-aware increment).
- Sub-module `arb_rr_pick` holds the combinational picker:
  - inputs: `request` and `ptr`;
  - outputs: winner one-hot and found flag;
  - implemented as double-width masked priority or rotate-search.
- `arb_rr_n` holds only the registers, the lock logic and the output decode.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `request`=4'b1111 -> `grant`=0, `grant_valid`=0, `grant_id`=0 throughout.
- Single request: drive `request`=4'b0100 one edge after reset, check two edges later -> `grant`=4'b0100, `grant_id`=2; drop the request -> `grant`=0 one edge later.
- Round-robin rotation: hold `request`=4'b1111 -> successive grants 0001, 0010, 0100, 1000, 0001.
- Non-power-of-two N=3 with `request`=3'b111 -> grants 001, 010, 100, 001; no out-of-range index appears.
- Lock (with `ARB_LOCK_EN`, N=4, `request`=4'b1111):
  - requester 1 granted with `lock`=1 for 3 cycles -> `grant` stays 4'b0010;
  - release `lock` -> next `grant`=4'b0100.
- Reset mid-operation: assert `rst` while `grant`=4'b1000 -> `grant`=0 after that edge; after release with `request`=4'b1001 -> `grant`=4'b0001.
